// File: rtl/tx_byte_arbiter.sv
// Round-robin, frame-locked arbiter sharing one byte-serial transmitter
// between N_REQ byte-stream requesters, with a per-byte watchdog.
//
// state | meaning
// IDLE  | no owner; pick next requester in round-robin order from ptr
// SEND  | owner granted; waiting for its byte, then launch tx_valid
// WAIT  | byte handed to transmitter; waiting for trans_done
// ACK   | req_done pulse out; release grant on last byte or fetch next
module tx_byte_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 65535,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_done,
    output logic [N_REQ-1:0]     grant,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 trans_done,
    output logic                 err_timeout,
    output logic                 busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, ACK} state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   nxt_ptr;
    logic [IDX_W-1:0]   cand;
    logic               sel_found;
    logic [CNT_W-1:0]   counter;
    logic               last_q;
    logic               wd_hit;
    int                 scan;

    // First requesting index at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr;
        scan      = 0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = int'(ptr) + k;
            if (scan >= N_REQ) begin
                scan = scan - N_REQ;
            end
            cand = IDX_W'(scan);
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign nxt_ptr = (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
    assign wd_hit  = (counter == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            gidx        <= '0;
            counter     <= '0;
            last_q      <= 1'b0;
            grant       <= '0;
            req_done    <= '0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            tx_valid    <= 1'b0;
            req_done    <= '0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant   <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
                        gidx    <= sel_idx;
                        counter <= '0;
                        busy    <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    counter <= counter + CNT_W'(1);
                    if (req_valid[gidx]) begin
                        tx_data  <= req_data[{gidx, 3'b000} +: 8];
                        last_q   <= req_last[gidx];
                        tx_valid <= 1'b1;
                        state    <= WAIT;
                    end else if (wd_hit) begin
                        err_timeout <= 1'b1;
                        grant       <= '0;
                        ptr         <= nxt_ptr;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                WAIT: begin
                    counter <= counter + CNT_W'(1);
                    // Completion on the watchdog's final cycle still counts as progress.
                    if (trans_done) begin
                        req_done <= grant;
                        state    <= ACK;
                    end else if (wd_hit) begin
                        err_timeout <= 1'b1;
                        grant       <= '0;
                        ptr         <= nxt_ptr;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                ACK: begin
                    if (last_q) begin
                        grant <= '0;
                        ptr   <= nxt_ptr;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        counter <= '0;
                        state   <= SEND;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_byte_arbiter.sv
// Scoreboard bench for tx_byte_arbiter: requester and transmitter models drive
// the DUT, a monitor pops expected bytes / completions / aborts as they appear.
`timescale 1ns/1ps
module tb_tx_byte_arbiter;

    localparam int N_REQ   = 2;
    localparam int TIMEOUT = 20;
    localparam int CNT_W   = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N_REQ-1:0]    req_valid = '0;
    logic [8*N_REQ-1:0]  req_data  = '0;
    logic [N_REQ-1:0]    req_last  = '0;
    logic [N_REQ-1:0]    req_done;
    logic [N_REQ-1:0]    grant;
    logic                tx_valid;
    logic [7:0]          tx_data;
    logic                trans_done = 1'b0;
    logic                err_timeout;
    logic                busy;

    tx_byte_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_done(req_done), .grant(grant),
        .tx_valid(tx_valid), .tx_data(tx_data), .trans_done(trans_done),
        .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] data; logic last; logic [7:0] gap; } item_t;
    typedef struct packed { logic [1:0] gnt; logic [7:0] data; } exp_t;

    item_t rq [N_REQ][$];
    exp_t  exp_tx[$];
    exp_t  exp_done[$];
    int    exp_err = 0;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc = 0;
    int    rise_cyc = 0;
    int    tx_times[$];
    logic [1:0] prev_grant = '0;

    logic  resp_en = 1'b1;
    int    resp_dly = 10;
    logic  force_td = 1'b0;
    logic  td_act = 1'b0;
    int    td_cnt = 0;
    int    gap_cnt [N_REQ];

    function automatic item_t mk(input logic [7:0] d, input logic l, input logic [7:0] g);
        item_t it;
        it.data = d; it.last = l; it.gap = g;
        return it;
    endfunction

    function automatic exp_t mke(input logic [1:0] g, input logic [7:0] d);
        exp_t e;
        e.gnt = g; e.data = d;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_byte(input logic [1:0] g, input logic [7:0] d);
        exp_tx.push_back(mke(g, d));
        exp_done.push_back(mke(g, d));
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_done.size() != 0 || exp_err != 0 ||
                rq[0].size() != 0 || rq[1].size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(name, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_tx(input string name, input int budget);
        int n;
        n = 0;
        while (!tx_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    // Requester model: holds a byte until its req_done, then presents the next after its gap.
    always @(negedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && req_done[i]) begin
                void'(rq[i].pop_front());
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                gap_cnt[i]   = 0;
                if (rq[i].size() != 0) begin
                    if (rq[i][0].gap == 8'd0) begin
                        req_valid[i]        = 1'b1;
                        req_data[8*i +: 8]  = rq[i][0].data;
                        req_last[i]         = rq[i][0].last;
                    end else begin
                        gap_cnt[i] = int'(rq[i][0].gap);
                    end
                end
            end else if (!req_valid[i] && rq[i].size() != 0) begin
                if (gap_cnt[i] <= 1) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = rq[i][0].data;
                    req_last[i]         = rq[i][0].last;
                    gap_cnt[i]          = 0;
                end else begin
                    gap_cnt[i] = gap_cnt[i] - 1;
                end
            end
        end
    end

    // Transmitter model: trans_done resp_dly cycles after tx_valid.
    always @(negedge clk) begin
        trans_done = 1'b0;
        if (rst || !resp_en) begin
            td_act = 1'b0;
        end else begin
            if (td_act) begin
                td_cnt = td_cnt - 1;
                if (td_cnt == 0) begin
                    trans_done = 1'b1;
                    td_act     = 1'b0;
                end
            end
            if (tx_valid) begin
                if (resp_dly == 0) begin
                    trans_done = 1'b1;
                end else begin
                    td_act = 1'b1;
                    td_cnt = resp_dly;
                end
            end
        end
        if (force_td) trans_done = 1'b1;
    end

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            prev_grant = '0;
        end else begin
            if (grant != prev_grant) begin
                chk("grant_handover", 32'(prev_grant != '0 && grant != '0), 32'd0);
                if (prev_grant == '0) rise_cyc = cyc;
                prev_grant = grant;
            end
            if (tx_valid) begin
                tx_times.push_back(cyc);
                if (exp_tx.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL tx_unexpected: got byte %02h grant %b, none expected", tx_data, grant);
                end else begin
                    e = exp_tx.pop_front();
                    chk("tx_byte", 32'({grant, tx_data}), 32'({e.gnt, e.data}));
                end
            end
            if (req_done != '0) begin
                if (exp_done.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL done_unexpected: got req_done %b, none expected", req_done);
                end else begin
                    e = exp_done.pop_front();
                    chk("req_done", 32'({req_done, tx_data}), 32'({e.gnt, e.data}));
                end
            end
            if (err_timeout) begin
                if (exp_err == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL err_unexpected: got err_timeout 1, expected 0");
                end else begin
                    exp_err--;
                    chk("wd_delay", 32'(cyc - rise_cyc), 32'(TIMEOUT));
                    chk("wd_grant", 32'(grant), 32'd0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_txv", 32'(tx_valid), 0);
        chk("rst_txd", 32'(tx_data), 0);
        chk("rst_done", 32'(req_done), 0);
        chk("rst_err", 32'(err_timeout), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_grant", 32'(grant), 0);

        // Single 4-byte frame from requester 0.
        tx_times.delete();
        resp_dly = 10;
        expect_byte(2'b01, 8'h12); expect_byte(2'b01, 8'h34);
        expect_byte(2'b01, 8'h56); expect_byte(2'b01, 8'h78);
        rq[0].push_back(mk(8'h12, 1'b0, 8'd0));
        rq[0].push_back(mk(8'h34, 1'b0, 8'd0));
        rq[0].push_back(mk(8'h56, 1'b0, 8'd0));
        rq[0].push_back(mk(8'h78, 1'b1, 8'd0));
        drain("single_drain", 300);
        chk("single_count", 32'(tx_times.size()), 32'd4);
        if (tx_times.size() == 4) begin
            chk("first_latency", 32'(tx_times[0] - rise_cyc), 32'd1);
            chk("byte_spacing", 32'(tx_times[1] - tx_times[0]), 32'd13);
        end
        chk("single_grant", 32'(grant), 0);
        chk("single_busy", 32'(busy), 0);
        chk("single_ptr", 32'(dut.ptr), 32'd1);

        // Contention from reset release; req 0 queues a second frame behind req 1.
        rst = 1'b1;
        resp_dly = 0;
        rq[0].push_back(mk(8'hA0, 1'b0, 8'd0));
        rq[0].push_back(mk(8'hA1, 1'b1, 8'd0));
        rq[0].push_back(mk(8'hA2, 1'b0, 8'd0));
        rq[0].push_back(mk(8'hA3, 1'b1, 8'd0));
        rq[1].push_back(mk(8'hB0, 1'b0, 8'd0));
        rq[1].push_back(mk(8'hB1, 1'b1, 8'd0));
        expect_byte(2'b01, 8'hA0); expect_byte(2'b01, 8'hA1);
        expect_byte(2'b10, 8'hB0); expect_byte(2'b10, 8'hB1);
        expect_byte(2'b01, 8'hA2); expect_byte(2'b01, 8'hA3);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drain("contend_drain", 300);
        chk("contend_ptr", 32'(dut.ptr), 32'd1);

        // Frame lock: req 1 arrives while req 0 stalls between bytes.
        resp_dly = 2;
        expect_byte(2'b01, 8'h21); expect_byte(2'b01, 8'h22);
        expect_byte(2'b01, 8'h23); expect_byte(2'b10, 8'h31);
        rq[0].push_back(mk(8'h21, 1'b0, 8'd0));
        rq[0].push_back(mk(8'h22, 1'b0, 8'd5));
        rq[0].push_back(mk(8'h23, 1'b1, 8'd5));
        wait_tx("lock_start", 50);
        rq[1].push_back(mk(8'h31, 1'b1, 8'd0));
        drain("lock_drain", 300);

        // Watchdog abort, then the same byte served normally.
        resp_en = 1'b0;
        exp_tx.push_back(mke(2'b01, 8'hE0));
        expect_byte(2'b01, 8'hE0);
        exp_err = 1;
        rq[0].push_back(mk(8'hE0, 1'b1, 8'd0));
        begin
            int n;
            n = 0;
            while (!err_timeout && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("wd_seen", 32'(n < 100), 32'd1);
        end
        resp_dly = 4;
        resp_en  = 1'b1;
        drain("wd_drain", 300);

        // Watchdog boundary: completion on the final counted cycle wins.
        resp_dly = 18;
        expect_byte(2'b01, 8'hF0);
        rq[0].push_back(mk(8'hF0, 1'b1, 8'd0));
        drain("wd_edge_drain", 300);

        // Async reset mid-WAIT, late trans_done, restart from req 0.
        resp_en = 1'b0;
        exp_tx.push_back(mke(2'b10, 8'hB1));
        rq[0].push_back(mk(8'hC0, 1'b1, 8'd0));
        rq[1].push_back(mk(8'hB1, 1'b1, 8'd0));
        wait_tx("arst_start", 50);
        @(negedge clk);
        chk("arst_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_txd", 32'(tx_data), 0);
        chk("arst_txv", 32'(tx_valid), 0);
        chk("arst_done", 32'(req_done), 0);
        expect_byte(2'b01, 8'hC0);
        expect_byte(2'b10, 8'hB1);
        @(posedge clk);
        #1 rst = 1'b0;
        force_td = 1'b1;
        @(posedge clk);
        #1 force_td = 1'b0;
        resp_dly = 3;
        resp_en  = 1'b1;
        drain("arst_drain", 300);
        chk("arst_ptr", 32'(dut.ptr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_byte_arbiter.md
Name: tx_byte_arbiter

Overview:
- Shares one byte-serial transmitter (tx_valid / tx_data / trans_done handshake) between N_REQ byte-stream requesters, e.g. several slave peripheral controllers serialising 32-bit addr+data words.
- Grants are round-robin and frame-locked: a grant is held until the requester's byte flagged last completes, so one frame's bytes are never interleaved with another's.
- A per-byte watchdog releases a stalled grant.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- TIMEOUT, 65535, maximum cycles spent in SEND+WAIT for one byte before abort.
- CNT_W, 16, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  N_REQ  requester i has a byte ready (level).
- req_data  in  8*N_REQ  byte of requester i at bits [8i+7:8i].
- req_last  in  N_REQ  requester i's current byte ends its frame.
- req_done  out  N_REQ  one-cycle pulse: requester i's byte was transmitted.
- grant  out  N_REQ  one-hot current owner; all zero when idle.
- tx_valid  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  8  byte to the transmitter; valid with tx_valid, held afterwards.
- trans_done  in  1  transmitter completion pulse.
- err_timeout  out  1  one-cycle pulse on watchdog abort.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, any state, mid-frame included):
  - state=IDLE, ptr=0, counter=0.
  - grant, req_done, tx_valid, tx_data, err_timeout and busy are all 0.
  - A byte in flight at the transmitter is abandoned; no req_done is issued for it.
- States: IDLE, SEND, WAIT, ACK. All outputs are registered.
- IDLE:
  - If any req_valid is high, select the first index i with req_valid[i]=1, scanning ptr, ptr+1, ... mod N_REQ.
  - Next cycle: grant=onehot(i), counter=0, state=SEND.
- SEND:
  - If req_valid[g]=1: latch tx_data=req_data[g], latch last_q=req_last[g], set tx_valid=1 for the next cycle only, go to WAIT.
  - Otherwise stay in SEND with the grant held (frame lock).
- WAIT:
  - tx_valid returns to 0.
  - On trans_done=1: req_done[g]=1 next cycle, state=ACK.
  - trans_done is accepted from the first WAIT cycle, which is the same cycle tx_valid is high.
- ACK:
  - req_done pulse is high; the requester updates req_valid/req_data/req_last at the end of this cycle.
  - If last_q=1: grant=0, ptr=(g+1) mod N_REQ, state=IDLE.
  - Otherwise counter=0, state=SEND.
- trans_done in IDLE, SEND or ACK is ignored.
- Watchdog:
  - counter clears on entry to SEND and increments every cycle in SEND or WAIT.
  - If counter==TIMEOUT-1 and no progress occurs this cycle (progress = req_valid[g] in SEND, or trans_done in WAIT), then: err_timeout pulses 1 cycle, grant=0, ptr=(g+1) mod N_REQ, state=IDLE, no req_done.
  - Progress in that same cycle wins over abort.
- Latency:
  - req_valid rising in IDLE at cycle 0 gives grant at cycle 1 and tx_valid at cycle 2.
  - trans_done at cycle t gives req_done at t+1.
  - Next byte's tx_valid at the earliest t+3.
  - Back-to-back frames: IDLE sits one cycle between frames.
- Simultaneous requests: only ptr order decides. A requester whose frame just ended has the lowest priority on the next arbitration.
- req_valid of non-granted requesters is ignored while a frame is active.
- tx_data holds its last value when idle.

Test Plan:
- Single frame: req 0 sends 4 bytes 0x12,0x34,0x56,0x78 (last on 0x78), transmitter returns trans_done 10 cycles after each tx_valid -> four tx_valid pulses with those bytes in order, four req_done[0] pulses, grant=01 throughout, then grant=00, busy=0, ptr=1.
- Contention and rotation: both requesters hold req_valid from reset release, each sending a 2-byte frame -> req 0 served first, then req 1 (grant 01 -> 00 -> 10), no interleaving; a repeat round starts with req 1.
- Frame lock: req 1 raises req_valid mid-frame of req 0 while req 0 stalls 5 cycles between bytes -> grant stays 01, and tx_data never carries req 1 bytes until req 0's last byte is acknowledged.
- Watchdog: TIMEOUT=20, trans_done is never returned -> err_timeout pulses exactly 20 cycles after SEND entry, grant=0, no req_done; the next request is served normally.
- Watchdog boundary: TIMEOUT=20, trans_done arrives on the 20th cycle -> req_done issued, no err_timeout.
- Async reset mid-WAIT: rst pulsed between tx_valid and trans_done -> all outputs 0 immediately (without waiting for a clock edge), a late trans_done is ignored, and arbitration restarts from req 0.
